// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Purpose:
//   Sequences one SPARC load/store between the datapath and an asynchronous
//   RAM that uses an MFA/MFC handshake. A request is accepted in IDLE. Its
//   opcode, address and store data are then held on the RAM side while MFA
//   is high. Load results are sign- or zero-extended into rdata. A RAM that
//   never answers is abandoned after TIMEOUT cycles, and the transfer
//   completes with err set.
//
// Parameters:
//   TIMEOUT       cycles MFA may stay high without MFC before the transfer
//                 is aborted (default 16)
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   start         one-cycle request strobe, only looked at in IDLE
//   op            SPARC load/store opcode of the request
//   addr          byte address of the request
//   wdata         store data of the request
//   rdata         extended load result, held until the next load completes
//   busy          transfer in progress (REQ or RELEASE)
//   done          one-cycle completion pulse
//   err           completion was an abort; cleared by the next accepted start
//   MFA           memory function active, to the RAM
//   mem_opcode    opcode to the RAM
//   mem_address   address to the RAM
//   mem_data_in   store data to the RAM
//   mem_data_out  read data from the RAM, valid while MFA and MFC are high
//   MFC           memory function complete, from the RAM (may be
//                 combinational on MFA)
//
// Configuration:
//   MEM_ALIGN_CHECK_EN  when defined, misaligned halfword/word requests are
//                       rejected without ever raising MFA.
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  op,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        MFA,
  output logic [5:0]  mem_opcode,
  output logic [7:0]  mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  input  logic        MFC
);

  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;
  localparam logic [5:0] OP_LD   = 6'b001000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;
  localparam logic [5:0] OP_ST   = 6'b000100;

  // The counter only ever has to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RELEASE,
    FIN
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          reject;
  logic          capture;
  logic          abort;
  logic          cnt_inc;
  logic          op_rejected;
  logic [31:0]   load_data;

  function automatic logic is_load(input logic [5:0] o);
    case (o)
      OP_LDSB, OP_LDSH, OP_LD, OP_LDUB, OP_LDUH: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] o);
    case (o)
      OP_STB, OP_STH, OP_ST: return 1'b1;
      default:               return 1'b0;
    endcase
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [5:0] o, input logic [7:0] a);
    case (o)
      OP_LDSH, OP_LDUH, OP_STH: return a[0];
      OP_LD, OP_ST:             return a[1:0] != 2'b00;
      default:                  return 1'b0;
    endcase
  endfunction
`endif

  // A request that would never reach the RAM: unsupported opcode (ldd/std
  // included) and, with the alignment check built in, a misaligned access.
  always_comb begin
`ifdef MEM_ALIGN_CHECK_EN
    op_rejected = !(is_load(op) || is_store(op)) || misaligned(op, addr);
`else
    op_rejected = !(is_load(op) || is_store(op));
`endif
  end

  // Extension works from the latched opcode. The incoming op may already
  // be a new, ignored request by the time MFC arrives.
  always_comb begin
    load_data = mem_data_out;
    case (mem_opcode)
      OP_LDSB: load_data = {{24{mem_data_out[7]}}, mem_data_out[7:0]};
      OP_LDUB: load_data = {24'h000000, mem_data_out[7:0]};
      OP_LDSH: load_data = {{16{mem_data_out[15]}}, mem_data_out[15:0]};
      OP_LDUH: load_data = {16'h0000, mem_data_out[15:0]};
      default: load_data = mem_data_out;
    endcase
  end

  // Next-state and control strobes. MFA, busy and done decode straight from
  // the state register. They are therefore glitch-free, and all three drop
  // on the edge that applies reset. MFC is checked before the timeout, so an
  // answer arriving on the last allowed cycle still completes normally.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    cnt_inc   = 1'b0;
    MFA       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (op_rejected) begin
            reject    = 1'b1;
            state_nxt = FIN;
          end else begin
            accept    = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        MFA  = 1'b1;
        busy = 1'b1;
        if (MFC) begin
          capture   = is_load(mem_opcode);
          state_nxt = RELEASE;
        end else if (cnt == CNT_LAST) begin
          abort     = 1'b1;
          state_nxt = RELEASE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RELEASE: begin
        busy = 1'b1;
        if (!MFC) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register and datapath. The RAM-side request registers load only
  // when a start is taken in IDLE. They therefore stay stable for the whole
  // handshake, even though start may be pulsed again while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      err         <= 1'b0;
      rdata       <= 32'h0;
      mem_opcode  <= 6'h0;
      mem_address <= 8'h0;
      mem_data_in <= 32'h0;
    end else begin
      state <= state_nxt;
      if (accept || reject) begin
        mem_opcode  <= op;
        mem_address <= addr;
        mem_data_in <= wdata;
        cnt         <= '0;
        err         <= reject;
      end
      if (cnt_inc) begin
        cnt <= cnt + CW'(1);
      end
      if (abort) begin
        err <= 1'b1;
      end
      if (capture) begin
        rdata <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Drives mem_access_ctrl against a behavioural RAM with a programmable MFC
// delay, MFC hold time and a no-response mode. Every issued request pushes
// its expected outcome onto a scoreboard queue: rdata, err, done latency and
// the number of MFA cycles. The expected values come from an abstract memory
// model. A separate monitor pops the queue on each done pulse and checks the
// request registers on every MFA cycle.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int TO = 16;

  localparam logic [5:0] LDSB = 6'b001001;
  localparam logic [5:0] LDSH = 6'b001010;
  localparam logic [5:0] LD   = 6'b001000;
  localparam logic [5:0] LDUB = 6'b000001;
  localparam logic [5:0] LDUH = 6'b000010;
  localparam logic [5:0] STB  = 6'b000101;
  localparam logic [5:0] STH  = 6'b000110;
  localparam logic [5:0] ST   = 6'b000100;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  op;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        MFA;
  logic [5:0]  mem_opcode;
  logic [7:0]  mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        MFC;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .MFA          (MFA),
    .mem_opcode   (mem_opcode),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .MFC          (MFC)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          mfa;
    int          startCyc;
    logic [5:0]  op;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sbq[$];
  exp_t        monItem;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mfaCnt = 0;
  bit          sbBypass = 1'b0;
  logic [31:0] ram    [256];
  logic [31:0] refmem [256];
  logic [31:0] lastRdata;
  int          ramDelay = 0;
  int          ramHold = 0;
  int          waitCnt = 0;
  int          holdLeft = 0;
  bit          ramRespond = 1'b1;

  // Behavioural RAM: MFC follows MFA combinationally after ramDelay cycles
  // and can be held for ramHold extra cycles after MFA falls.
  assign MFC = (MFA && ramRespond && (waitCnt >= ramDelay)) || (holdLeft != 0);
  assign mem_data_out = MFA ? ram[mem_address] : 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (MFA && MFC) begin
      case (mem_opcode)
        ST:      ram[mem_address]       <= mem_data_in;
        STH:     ram[mem_address][15:0] <= mem_data_in[15:0];
        STB:     ram[mem_address][7:0]  <= mem_data_in[7:0];
        default: ;
      endcase
      holdLeft <= ramHold;
      waitCnt  <= 0;
    end else begin
      waitCnt <= MFA ? waitCnt + 1 : 0;
      if (holdLeft != 0) holdLeft <= holdLeft - 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model helpers: access size in bytes (0 = unsupported).
  function automatic int sizeOf(input logic [5:0] o);
    if (o == LDSB || o == LDUB || o == STB) return 1;
    if (o == LDSH || o == LDUH || o == STH) return 2;
    if (o == LD || o == ST) return 4;
    return 0;
  endfunction

  function automatic bit isLoadOp(input logic [5:0] o);
    return (o == LDSB || o == LDSH || o == LD || o == LDUB || o == LDUH);
  endfunction

  function automatic logic [31:0] loadValue(input logic [5:0] o, input logic [31:0] word);
    longint span;
    longint v;
    if (sizeOf(o) == 4) return word;
    span = longint'(1) << (8 * sizeOf(o));
    v = longint'(word) % span;
    if ((o == LDSB || o == LDSH) && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  function automatic logic [31:0] storeValue(input logic [5:0] o, input logic [31:0] old,
                                             input logic [31:0] wd);
    longint span;
    longint oldv;
    if (sizeOf(o) == 4) return wd;
    span = longint'(1) << (8 * sizeOf(o));
    oldv = longint'(old);
    return 32'(oldv - (oldv % span) + (longint'(wd) % span));
  endfunction

  // Monitor: checks the held request registers while MFA is high and
  // scores each completion against the head of the queue.
  always @(negedge clk) begin
    if (reset) begin
      mfaCnt = 0;
    end else begin
      if (MFA && !sbBypass) begin
        mfaCnt++;
        checkOutput("busy during MFA", 32'(busy), 32'd1);
        if (sbq.size() > 0) begin
          checkOutput("mem_opcode", 32'(mem_opcode), 32'(sbq[0].op));
          checkOutput("mem_address", 32'(mem_address), 32'(sbq[0].addr));
          checkOutput("mem_data_in", mem_data_in, sbq[0].wdata);
        end else begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected MFA: got 1, expected 0");
        end
      end
      if (done) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL spurious done: got 1, expected 0");
        end else begin
          monItem = sbq.pop_front();
          checkOutput("rdata", rdata, monItem.rdata);
          checkOutput("err", 32'(err), 32'(monItem.err));
          checkOutput("latency", 32'(cyc - monItem.startCyc), 32'(monItem.lat));
          checkOutput("MFA cycles", 32'(mfaCnt), 32'(monItem.mfa));
          checkOutput("busy at done", 32'(busy), 32'd0);
        end
        mfaCnt = 0;
      end
    end
  end

  task automatic applyStimulus(input logic [5:0] o, input logic [7:0] a, input logic [31:0] wd,
                               input int dly, input int hld, input bit resp);
    exp_t e;
    int   sz;
    bit   bad;
    int   extra;
    int   n;
    @(negedge clk);
    ramDelay   = dly;
    ramHold    = hld;
    ramRespond = resp;
    sz  = sizeOf(o);
    bad = (sz == 0);
`ifdef MEM_ALIGN_CHECK_EN
    if (sz != 0 && (int'(a) % sz) != 0) bad = 1'b1;
`endif
    e.op = o;
    e.addr = a;
    e.wdata = wd;
    e.startCyc = cyc + 1;
    if (bad) begin
      e.err = 1'b1; e.lat = 0; e.mfa = 0; e.rdata = lastRdata;
    end else if (!resp || dly >= TO) begin
      e.err = 1'b1; e.lat = TO + 1; e.mfa = TO; e.rdata = lastRdata;
    end else begin
      e.err = 1'b0; e.mfa = dly + 1; e.lat = dly + 2 + hld;
      if (isLoadOp(o)) lastRdata = loadValue(o, refmem[a]);
      else refmem[a] = storeValue(o, refmem[a], wd);
      e.rdata = lastRdata;
    end
    sbq.push_back(e);
    start = 1'b1;
    op    = o;
    addr  = a;
    wdata = wd;
    @(negedge clk);
    extra = $urandom_range(0, 1);
    repeat (extra) begin
      op    = 6'($urandom);
      addr  = 8'($urandom);
      wdata = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done timeout: got no done, expected done within 200 cycles");
      sbq.delete();
    end
  endtask

  initial begin
    logic [5:0] o;
    logic [7:0] a;
    int         r;
    int         dly;
    reset = 1'b1;
    start = 1'b0;
    op    = 6'h0;
    addr  = 8'h0;
    wdata = 32'h0;
    for (int i = 0; i < 256; i++) begin
      ram[i]    = $urandom;
      refmem[i] = ram[i];
    end
    lastRdata = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset rdata", rdata, 32'h0);
    checkOutput("reset MFA", 32'(MFA), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    checkOutput("reset mem_opcode", 32'(mem_opcode), 32'd0);
    checkOutput("reset mem_address", 32'(mem_address), 32'd0);
    checkOutput("reset mem_data_in", mem_data_in, 32'h0);
    reset = 1'b0;

    $display("[TB] directed word/byte/halfword transfers");
    applyStimulus(ST, 8'h10, 32'hDEADBEEF, 0, 0, 1'b1);
    applyStimulus(LD, 8'h10, 32'h0, 0, 0, 1'b1);
    checkOutput("ld 0x10 value", rdata, 32'hDEADBEEF);
    checkOutput("ld 0x10 err", 32'(err), 32'd0);
    applyStimulus(STB, 8'h20, 32'hABCDEF80, 0, 0, 1'b1);
    applyStimulus(LDSB, 8'h20, 32'h0, 0, 0, 1'b1);
    checkOutput("ldsb 0x20 value", rdata, 32'hFFFFFF80);
    applyStimulus(LDUB, 8'h20, 32'h0, 0, 0, 1'b1);
    checkOutput("ldub 0x20 value", rdata, 32'h00000080);
    applyStimulus(STH, 8'h30, 32'h12348001, 0, 0, 1'b1);
    applyStimulus(LDSH, 8'h30, 32'h0, 0, 0, 1'b1);
    checkOutput("ldsh 0x30 value", rdata, 32'hFFFF8001);
    applyStimulus(LDUH, 8'h30, 32'h0, 0, 0, 1'b1);
    checkOutput("lduh 0x30 value", rdata, 32'h00008001);

    $display("[TB] timeout and unsupported opcodes");
    applyStimulus(LD, 8'h10, 32'h0, 0, 0, 1'b0);
    checkOutput("timeout rdata kept", rdata, 32'h00008001);
    checkOutput("timeout err", 32'(err), 32'd1);
    applyStimulus(6'b000011, 8'h10, 32'h0, 0, 0, 1'b1);
    checkOutput("ldd err", 32'(err), 32'd1);
    applyStimulus(6'b000111, 8'h10, 32'h11111111, 0, 0, 1'b1);
    applyStimulus(ST, 8'h10, 32'h55555555, 0, 0, 1'b0);
    applyStimulus(LD, 8'h10, 32'h0, 3, 2, 1'b1);
    checkOutput("ld after aborted st", rdata, 32'hDEADBEEF);
    applyStimulus(LD, 8'h30, 32'h0, TO - 1, 0, 1'b1);
    applyStimulus(LD, 8'h30, 32'h0, TO, 0, 1'b1);

    $display("[TB] reset during a transfer");
    @(negedge clk);
    sbBypass   = 1'b1;
    ramRespond = 1'b0;
    start = 1'b1; op = LD; addr = 8'h44; wdata = 32'h0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("MFA before reset", 32'(MFA), 32'd1);
    checkOutput("busy before reset", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid reset MFA", 32'(MFA), 32'd0);
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    checkOutput("mid reset done", 32'(done), 32'd0);
    checkOutput("mid reset rdata", rdata, 32'h0);
    checkOutput("mid reset mem_address", 32'(mem_address), 32'd0);
    start = 1'b1; op = LD; addr = 8'h10;
    @(negedge clk);
    checkOutput("reset over start MFA", 32'(MFA), 32'd0);
    checkOutput("reset over start busy", 32'(busy), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    lastRdata  = 32'h0;
    ramRespond = 1'b1;
    sbBypass   = 1'b0;
    repeat (TO + 4) @(negedge clk);

`ifdef MEM_ALIGN_CHECK_EN
    $display("[TB] misaligned requests");
    applyStimulus(LD, 8'h02, 32'h0, 0, 0, 1'b1);
    checkOutput("misaligned ld err", 32'(err), 32'd1);
    applyStimulus(STH, 8'h31, 32'h0, 0, 0, 1'b1);
`endif

    $display("[TB] randomized transfers");
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: o = LDSB;
        1: o = LDSH;
        2: o = LD;
        3: o = LDUB;
        4: o = LDUH;
        5: o = STB;
        6: o = STH;
        7: o = ST;
        default: o = 6'($urandom);
      endcase
      a = 8'h40 + 8'($urandom_range(0, 15));
      r = $urandom_range(0, 19);
      dly = (r < 17) ? (r % 4) : (TO - 1 + (r - 17));
      applyStimulus(o, a, $urandom, dly, $urandom_range(0, 2), ($urandom_range(0, 15) != 0));
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
